aes_cipher_iter: RTL and testbench
==================================

AES_CIPHER_ITER -- requirements
Module: aes_cipher_iter

Interface
REQ-001 Parameter: KEY_BITS, 128, cipher key length; legal values 128/192/256, any other value SHALL fail elaboration.
REQ-002 Derived constants: Nk = KEY_BITS/32 (4/6/8); Nr = Nk+6 (10/12/14); NW = 4*(Nr+1) schedule words (44/52/60).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  global advance; low freezes all state.
REQ-006 in_valid  input  1  plaintext/key offered.
REQ-007 in_ready  output  1  block can accept.
REQ-008 in_keep_key  input  1  reuse stored key schedule, ignore key.
REQ-009 plaintext  input  128  FIPS-197 byte order, byte 0 = bits [127:120].
REQ-010 key  input  KEY_BITS  cipher key, word 0 = MSBs.
REQ-011 out_valid  output  1  ciphertext available.
REQ-012 out_ready  input  1  consumer takes ciphertext.
REQ-013 ciphertext  output  128  result, same byte order as plaintext.

Function
REQ-014 FSM states SHALL be IDLE, KEXP, ROUND, HOLD.
REQ-015 in_ready SHALL equal (state==IDLE) & enable & ~reset.
REQ-016 Accept = in_valid & in_ready; on accept, plaintext is registered, round counter cleared.
REQ-017 Accept with in_keep_key=0, or with in_keep_key=1 while sched_ok=0: words 0..Nk-1 loaded from key, sched_ok cleared, IDLE->KEXP.
REQ-018 Accept with in_keep_key=1 and sched_ok=1: key ignored, schedule untouched, IDLE->ROUND.
REQ-019 KEXP generates one schedule word per enabled cycle, index Nk..NW-1, per FIPS-197 (RotWord/SubWord/Rcon at i mod Nk==0; SubWord only at i mod Nk==4 when Nk==8); after word NW-1 sched_ok set, KEXP->ROUND.
REQ-020 ROUND performs one round per enabled cycle: round 0 AddRoundKey only; rounds 1..Nr-1 SubBytes, ShiftRows, MixColumns, AddRoundKey; round Nr omits MixColumns; after round Nr ciphertext registered, ROUND->HOLD.
REQ-021 S-box SHALL be computed in-block (GF(2^8) inverse plus affine transform), 16 instances for state, 4 for SubWord; no external tables.
REQ-022 Latency, accept cycle to first out_valid=1 cycle, with enable held high: full expansion LAT = NW-Nk+Nr+2 (52/60/68); key reuse LAT = Nr+2 (12/14/16).
REQ-023 HOLD: out_valid=1, ciphertext stable; out_valid & out_ready & enable -> IDLE next cycle; out_valid deasserts that cycle.
REQ-024 No accept while out_valid=1; the next accept is possible at earliest the cycle after the handshake.
REQ-025 enable=0: state, counters, schedule, outputs frozen; out_valid held; handshakes do not complete; latency extends by exactly the number of low-enable cycles.
REQ-026 Inputs plaintext, key, in_keep_key are sampled only on accept; changes later SHALL not affect the result.

Reset
REQ-027 reset=1 at an edge: state=IDLE, out_valid=0, ciphertext=0, sched_ok=0, counters=0; dominates enable and all handshakes.
REQ-028 Reset mid-KEXP/ROUND/HOLD aborts the operation; the result is never presented; the next accept SHALL perform full expansion even if in_keep_key=1.
REQ-029 Schedule RAM contents need not be cleared; sched_ok gates their use.

Verification
REQ-030 KEY_BITS=128, key 000102..0f, pt 00112233445566778899aabbccddeeff, keep=0 -> ct 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 52 cycles after accept.
REQ-031 KEY_BITS=192, key 000102..17, same pt -> ct dda97ca4864cdfe06eaf70a0ec0d7191 at 60 cycles; KEY_BITS=256, key 000102..1f -> ct 8ea2b7ca516745bfeafc49904b496089 at 68 cycles.
REQ-032 KEY_BITS=128: after REQ-030, second accept with keep=1, key bus driven with ff..ff, same pt -> same ct at 12 cycles.
REQ-033 out_ready held 0 for 20 cycles in HOLD -> out_valid and ct stable, in_ready=0 throughout; enable toggled low 7 cycles mid-ROUND -> LAT becomes 59 (128-bit), ct unchanged.
REQ-034 reset pulsed 1 cycle mid-KEXP, then accept with keep=1 -> full expansion (52 cycles), correct ct; out_valid never rose for the aborted operation.

Source files
------------

// File: rtl/aes_cipher_iter_if.sv
// aes_cipher_iter_if -- request/response bundle for the iterative AES cipher.
//   in_valid/in_ready    : plaintext+key offer handshake
//   in_keep_key          : reuse the stored key schedule (key bus ignored)
//   plaintext[127:0]     : FIPS-197 byte order, byte 0 = bits [127:120]
//   key[KEY_BITS-1:0]    : cipher key, word 0 in the MSBs
//   out_valid/out_ready  : ciphertext handshake
//   ciphertext[127:0]    : result, same byte order as plaintext
// master = traffic source/sink (bench), slave = the cipher block.
interface aes_cipher_iter_if #(
   parameter int KEY_BITS = 128
) ();
   logic                in_valid;
   logic                in_ready;
   logic                in_keep_key;
   logic [127:0]        plaintext;
   logic [KEY_BITS-1:0] key;
   logic                out_valid;
   logic                out_ready;
   logic [127:0]        ciphertext;

   modport master (
      output in_valid, in_keep_key, plaintext, key, out_ready,
      input  in_ready, out_valid, ciphertext
   );

   modport slave (
      input  in_valid, in_keep_key, plaintext, key, out_ready,
      output in_ready, out_valid, ciphertext
   );
endinterface

// File: rtl/aes_cipher_iter.sv
// aes_cipher_iter -- iterative AES encryptor (AES-128/192/256 by KEY_BITS).
// Expands the key one schedule word per cycle (KEXP), then runs one round
// per cycle (ROUND) and presents the result until it is taken (HOLD).
// A stored schedule can be reused for later blocks via in_keep_key.
// Ports:
//   clk    : sole clock, rising edge
//   reset  : synchronous, active high; aborts any operation
//   enable : global advance; low freezes every register
//   bus    : aes_cipher_iter_if.slave (in/out handshakes, data)

// Single S-box lane: multiplicative inverse in GF(2^8) followed by the
// FIPS-197 affine transform. No lookup table.
module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] s
);
   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = x;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) p = p ^ t;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // a^254 = product of a^(2^k), k=1..7; maps 0 to 0 as required.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = gmul(x, x);
      inv = sq;
      for (int k = 2; k < 8; k++) begin
         sq  = gmul(sq, sq);
         inv = gmul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   assign s = sbox(a);
endmodule

module aes_cipher_iter #(
   parameter int KEY_BITS = 128
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   aes_cipher_iter_if.slave bus
);
   localparam int NK = KEY_BITS / 32;
   localparam int NR = NK + 6;
   localparam int NW = 4 * (NR + 1);
   localparam int WW = 6;               // schedule index width, NW <= 60

   if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
      $error("aes_cipher_iter: KEY_BITS must be 128, 192 or 256");
   end

   typedef enum logic [1:0] {IDLE, KEXP, ROUND, HOLD} state_t;

   state_t           state, state_n;
   logic             sched_ok;
   logic [WW-1:0]    widx;              // next schedule word to generate
   logic [2:0]       kmod;              // widx mod NK, kept as a counter
   logic [7:0]       rc;                // Rcon byte for the next kmod==0 word
   logic [3:0]       rnd;
   logic [15:0][7:0] st;                // byte 0 sits in st[15]
   logic [127:0]     ct_q;
   logic [31:0]      w [NW];            // schedule RAM, not reset

   logic             accept, full_exp, last_word, last_round;

   assign bus.in_ready   = (state == IDLE) & enable & ~reset;
   assign accept         = bus.in_valid & bus.in_ready;
   // keep_key only helps when a complete schedule is already stored
   assign full_exp       = ~bus.in_keep_key | ~sched_ok;
   assign last_word      = (widx == WW'(NW - 1));
   assign last_round     = (rnd == 4'(NR));
   assign bus.out_valid  = (state == HOLD);
   assign bus.ciphertext = ct_q;

   // ---------------- key expansion datapath ----------------
   logic [31:0] kprev, kfar, sw_in, sw_out, knew;
   logic        is_rc, is_sub8;

   always_comb begin
      kprev   = w[widx - WW'(1)];
      kfar    = w[widx - WW'(NK)];
      is_rc   = (kmod == 3'd0);
      is_sub8 = (NK == 8) && (kmod == 3'd4);
      sw_in   = is_rc ? {kprev[23:0], kprev[31:24]} : kprev;
      if (is_rc)        knew = kfar ^ sw_out ^ {rc, 24'h000000};
      else if (is_sub8) knew = kfar ^ sw_out;
      else              knew = kfar ^ kprev;
   end

   for (genvar j = 0; j < 4; j++) begin : g_ksb
      aes_sbox u_sb (.a(sw_in[8*j +: 8]), .s(sw_out[8*j +: 8]));
   end

   // ---------------- round datapath ----------------
   logic [15:0][7:0] sb, sr, mc;
   logic [127:0]     rk, rnd_out;

   for (genvar n = 0; n < 16; n++) begin : g_ssb
      aes_sbox u_sb (.a(st[n]), .s(sb[n]));
   end

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mixcol(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
              xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
   endfunction

   always_comb begin
      sr = '0;
      mc = '0;
      // byte 4c+r (row r, column c) lives at index 15-(4c+r)
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            sr[15 - (4*c + r)] = sb[15 - (4*((c + r) % 4) + r)];
      for (int c = 0; c < 4; c++)
         mc[4*(3 - c) +: 4] = mixcol(sr[4*(3 - c) +: 4]);
      rk = {w[{rnd, 2'b00}], w[{rnd, 2'b01}], w[{rnd, 2'b10}], w[{rnd, 2'b11}]};
      if (rnd == 4'd0)     rnd_out = st ^ rk;
      else if (last_round) rnd_out = sr ^ rk;
      else                 rnd_out = mc ^ rk;
   end

   // ---------------- control FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (accept) state_n = full_exp ? KEXP : ROUND;
         KEXP:    if (enable && last_word) state_n = ROUND;
         ROUND:   if (enable && last_round) state_n = HOLD;
         HOLD:    if (enable && bus.out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         sched_ok <= 1'b0;
         widx     <= '0;
         kmod     <= '0;
         rc       <= '0;
         rnd      <= '0;
         st       <= '0;
         ct_q     <= '0;
      end else if (enable) begin
         case (state)
            IDLE: if (accept) begin
               st  <= bus.plaintext;
               rnd <= '0;
               if (full_exp) begin
                  sched_ok <= 1'b0;
                  widx     <= WW'(NK);
                  kmod     <= '0;
                  rc       <= 8'h01;
               end
            end
            KEXP: begin
               widx <= widx + WW'(1);
               kmod <= (kmod == 3'(NK - 1)) ? 3'd0 : kmod + 3'd1;
               if (is_rc)     rc       <= xt(rc);
               if (last_word) sched_ok <= 1'b1;
            end
            ROUND: begin
               st  <= rnd_out;
               rnd <= rnd + 4'd1;
               if (last_round) ct_q <= rnd_out;
            end
            default: ;
         endcase
      end
   end

   // Schedule RAM: contents survive reset; sched_ok decides whether they count.
   always_ff @(posedge clk) begin
      if (accept && full_exp) begin
         for (int j = 0; j < NK; j++)
            w[j] <= bus.key[KEY_BITS - 1 - 32*j -: 32];
      end else if (!reset && enable && state == KEXP) begin
         w[widx] <= knew;
      end
   end
endmodule

// File: tb/tb_aes_cipher_iter.sv
module tb_aes_cipher_iter;
   logic clk = 1'b0;
   logic reset, enable;
   always #5 clk = ~clk;

   aes_cipher_iter_if #(.KEY_BITS(128)) b128 ();
   aes_cipher_iter_if #(.KEY_BITS(192)) b192 ();
   aes_cipher_iter_if #(.KEY_BITS(256)) b256 ();

   aes_cipher_iter #(.KEY_BITS(128)) dut128 (.clk(clk), .reset(reset), .enable(enable), .bus(b128.slave));
   aes_cipher_iter #(.KEY_BITS(192)) dut192 (.clk(clk), .reset(reset), .enable(enable), .bus(b192.slave));
   aes_cipher_iter #(.KEY_BITS(256)) dut256 (.clk(clk), .reset(reset), .enable(enable), .bus(b256.slave));

   int n_chk = 0;
   int n_fail = 0;

   localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   // ---------------- reference model ----------------
   logic [7:0] sbox_t [256];
   logic [127:0] m_key;
   bit           m_sched;

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Inverse found by search, affine transform bit by bit.
   task automatic build_sbox();
      logic [7:0] inv, s, c, yb;
      c = 8'h63;
      for (int v = 0; v < 256; v++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            yb = y[7:0];
            if (gm(v[7:0], yb) == 8'h01) inv = yb;
         end
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
         sbox_t[v] = s;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] t);
      return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
   endfunction

   // key left-aligned in 256 bits
   function automatic logic [127:0] aes_ref(input logic [255:0] k, input int nk, input logic [127:0] pt);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  s [4][4];
      logic [7:0]  u [4][4];
      logic [7:0]  rcv, a0, a1, a2, a3;
      logic [127:0] o;
      int nr;
      nr = nk + 6;
      for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t = subw({t[23:0], t[31:24]});
            rcv = 8'h01;
            for (int j = 1; j < i/nk; j++) rcv = gm(rcv, 8'h02);
            t = t ^ {rcv, 24'h0};
         end else if (nk > 6 && i % nk == 4) begin
            t = subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) s[r][c] = pt[127 - 8*(4*c+r) -: 8];
      for (int rd = 0; rd <= nr; rd++) begin
         if (rd > 0) begin
            for (int c = 0; c < 4; c++)
               for (int r = 0; r < 4; r++) u[r][c] = sbox_t[s[r][(c+r)%4]];
            for (int c = 0; c < 4; c++)
               for (int r = 0; r < 4; r++) s[r][c] = u[r][c];
            if (rd < nr) begin
               for (int c = 0; c < 4; c++) begin
                  a0 = s[0][c]; a1 = s[1][c]; a2 = s[2][c]; a3 = s[3][c];
                  s[0][c] = gm(a0,8'h02) ^ gm(a1,8'h03) ^ a2 ^ a3;
                  s[1][c] = a0 ^ gm(a1,8'h02) ^ gm(a2,8'h03) ^ a3;
                  s[2][c] = a0 ^ a1 ^ gm(a2,8'h02) ^ gm(a3,8'h03);
                  s[3][c] = gm(a0,8'h03) ^ a1 ^ a2 ^ gm(a3,8'h02);
               end
            end
         end
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ w[4*rd+c][31 - 8*r -: 8];
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) o[127 - 8*(4*c+r) -: 8] = s[r][c];
      return o;
   endfunction

   // Tracks which key the stored schedule holds; yields expected ct and latency.
   task automatic model_op(input logic [127:0] k, input logic keep, input logic [127:0] pt,
                           output logic [127:0] ect, output int elat);
      bit full;
      full = !keep || !m_sched;
      if (full) m_key = k;
      m_sched = 1;
      ect  = aes_ref({m_key, 128'h0}, 4, pt);
      elat = full ? 52 : 12;
   endtask

   // Drive one 128-bit operation; lat=-1 if out_valid never rose within max_n.
   task automatic op128(input logic [127:0] k, input logic keep, input logic [127:0] pt,
                        input int stall_at, input int rst_at, input int max_n,
                        output int lat, output logic [127:0] ct, output bit busy_ok);
      int n, g;
      @(negedge clk);
      b128.in_valid = 1'b1; b128.key = k; b128.in_keep_key = keep; b128.plaintext = pt;
      g = 0;
      while (!b128.in_ready && g < 100) begin @(negedge clk); g++; end
      @(posedge clk); #1;
      b128.in_valid = 1'b0;
      b128.key = {$urandom, $urandom, $urandom, $urandom};
      b128.plaintext = {$urandom, $urandom, $urandom, $urandom};
      b128.in_keep_key = 1'($urandom_range(0, 1));
      n = 0; lat = -1; busy_ok = 1;
      while (n < max_n) begin
         @(negedge clk); n++;
         if (b128.out_valid) begin lat = n; break; end
         if (b128.in_ready) busy_ok = 0;
         if (n == stall_at) enable = 1'b0;
         if (n == stall_at + 7) enable = 1'b1;
         if (n == rst_at) reset = 1'b1;
         if (n == rst_at + 1) reset = 1'b0;
      end
      ct = b128.ciphertext;
      enable = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1; enable = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_chk++; if (b128.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ov128: got %b want 0", b128.out_valid); end
      n_chk++; if (b192.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ov192: got %b want 0", b192.out_valid); end
      n_chk++; if (b256.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ov256: got %b want 0", b256.out_valid); end
      n_chk++; if (b128.ciphertext !== 128'h0) begin n_fail++; $display("FAIL rst_ct: got %h want 0", b128.ciphertext); end
      n_chk++; if (b128.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_inready_hi: got %b want 0", b128.in_ready); end
      reset = 1'b0; #1;
      n_chk++; if (b128.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_inready_lo: got %b want 1", b128.in_ready); end
      m_sched = 0;
   endtask

   task automatic test_vec128();
      logic [127:0] ct, ect; int lat, elat; bit busy;
      b128.out_ready = 1'b1;
      model_op(K128, 1'b0, PT, ect, elat);
      op128(K128, 1'b0, PT, -1, -1, 200, lat, ct, busy);
      n_chk++; if (ct !== CT128) begin n_fail++; $display("FAIL vec128_ct: got %h want %h", ct, CT128); end
      n_chk++; if (lat !== elat) begin n_fail++; $display("FAIL vec128_lat: got %0d want %0d", lat, elat); end
      n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL vec128_busy: in_ready rose while busy"); end
   endtask

   task automatic test_keep_key();
      logic [127:0] ct, ect; int lat, elat; bit busy;
      model_op('1, 1'b1, PT, ect, elat);
      op128('1, 1'b1, PT, -1, -1, 200, lat, ct, busy);
      n_chk++; if (ct !== CT128) begin n_fail++; $display("FAIL keep_ct: got %h want %h", ct, CT128); end
      n_chk++; if (lat !== elat) begin n_fail++; $display("FAIL keep_lat: got %0d want %0d", lat, elat); end
   endtask

   task automatic test_vec_wide();
      int n, g, lat;
      @(negedge clk);
      b192.in_valid = 1'b1; b192.in_keep_key = 1'b0; b192.plaintext = PT; b192.out_ready = 1'b1;
      b192.key = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
      g = 0;
      while (!b192.in_ready && g < 50) begin @(negedge clk); g++; end
      @(posedge clk); #1;
      b192.in_valid = 1'b0; b192.key = '1;
      n = 0; lat = -1;
      while (n < 200) begin @(negedge clk); n++; if (b192.out_valid) begin lat = n; break; end end
      n_chk++; if (b192.ciphertext !== 128'hdda97ca4864cdfe06eaf70a0ec0d7191) begin n_fail++; $display("FAIL vec192_ct: got %h", b192.ciphertext); end
      n_chk++; if (lat !== 60) begin n_fail++; $display("FAIL vec192_lat: got %0d want 60", lat); end

      @(negedge clk);
      b256.in_valid = 1'b1; b256.in_keep_key = 1'b0; b256.plaintext = PT; b256.out_ready = 1'b1;
      b256.key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
      g = 0;
      while (!b256.in_ready && g < 50) begin @(negedge clk); g++; end
      @(posedge clk); #1;
      b256.in_valid = 1'b0; b256.key = '0;
      n = 0; lat = -1;
      while (n < 200) begin @(negedge clk); n++; if (b256.out_valid) begin lat = n; break; end end
      n_chk++; if (b256.ciphertext !== 128'h8ea2b7ca516745bfeafc49904b496089) begin n_fail++; $display("FAIL vec256_ct: got %h", b256.ciphertext); end
      n_chk++; if (lat !== 68) begin n_fail++; $display("FAIL vec256_lat: got %0d want 68", lat); end
   endtask

   task automatic test_hold_stall();
      logic [127:0] ct, ect, pt; int lat, elat; bit busy, stable;
      pt = {$urandom, $urandom, $urandom, $urandom};
      b128.out_ready = 1'b0;
      model_op('0, 1'b1, pt, ect, elat);
      op128('0, 1'b1, pt, -1, -1, 200, lat, ct, busy);
      n_chk++; if (ct !== ect) begin n_fail++; $display("FAIL hold_ct: got %h want %h", ct, ect); end
      n_chk++; if (lat !== elat) begin n_fail++; $display("FAIL hold_lat: got %0d want %0d", lat, elat); end
      stable = 1;
      repeat (20) begin
         @(negedge clk);
         if (b128.out_valid !== 1'b1 || b128.ciphertext !== ct || b128.in_ready !== 1'b0) stable = 0;
      end
      n_chk++; if (stable !== 1'b1) begin n_fail++; $display("FAIL hold_stable: output moved or in_ready rose during stall"); end
      b128.out_ready = 1'b1;
      @(negedge clk);
      n_chk++; if (b128.out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release_ov: got %b want 0", b128.out_valid); end
      n_chk++; if (b128.in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release_ir: got %b want 1", b128.in_ready); end
   endtask

   task automatic test_enable_stall();
      logic [127:0] ct, ect, k, pt; int lat, elat; bit busy;
      k = {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom};
      model_op(k, 1'b0, pt, ect, elat);
      op128(k, 1'b0, pt, 45, -1, 200, lat, ct, busy);
      n_chk++; if (ct !== ect) begin n_fail++; $display("FAIL en_stall_ct: got %h want %h", ct, ect); end
      n_chk++; if (lat !== elat + 7) begin n_fail++; $display("FAIL en_stall_lat: got %0d want %0d", lat, elat + 7); end
   endtask

   task automatic test_reset_abort();
      logic [127:0] ct, ect, k, pt; int lat, elat; bit busy;
      k = {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom};
      op128(k, 1'b0, pt, -1, 20, 90, lat, ct, busy);
      n_chk++; if (lat !== -1) begin n_fail++; $display("FAIL abort_ov: out_valid rose at %0d want never", lat); end
      m_sched = 0;
      k = {$urandom, $urandom, $urandom, $urandom};
      model_op(k, 1'b1, PT, ect, elat);
      op128(k, 1'b1, PT, -1, -1, 200, lat, ct, busy);
      n_chk++; if (ct !== ect) begin n_fail++; $display("FAIL abort_next_ct: got %h want %h", ct, ect); end
      n_chk++; if (lat !== 52) begin n_fail++; $display("FAIL abort_next_lat: got %0d want 52", lat); end
   endtask

   task automatic test_back_to_back();
      logic [127:0] ct, ect, pt; int lat, elat; bit busy;
      for (int i = 0; i < 2; i++) begin
         pt = {$urandom, $urandom, $urandom, $urandom};
         model_op('0, 1'b1, pt, ect, elat);
         op128('0, 1'b1, pt, -1, -1, 200, lat, ct, busy);
         n_chk++; if (b128.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ir_hold%0d: got %b want 0", i, b128.in_ready); end
         n_chk++; if (ct !== ect) begin n_fail++; $display("FAIL b2b_ct%0d: got %h want %h", i, ct, ect); end
         @(negedge clk);
         n_chk++; if (b128.in_ready !== 1'b1 || b128.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_next%0d: in_ready %b out_valid %b want 1 0", i, b128.in_ready, b128.out_valid); end
      end
   endtask

   task automatic test_random();
      logic [127:0] ct, ect, k, pt; logic keep; int lat, elat; bit busy;
      for (int i = 0; i < 8; i++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         pt = {$urandom, $urandom, $urandom, $urandom};
         keep = 1'($urandom_range(0, 1));
         model_op(k, keep, pt, ect, elat);
         op128(k, keep, pt, -1, -1, 200, lat, ct, busy);
         n_chk++; if (ct !== ect) begin n_fail++; $display("FAIL rand_ct%0d: got %h want %h", i, ct, ect); end
         n_chk++; if (lat !== elat) begin n_fail++; $display("FAIL rand_lat%0d: got %0d want %0d", i, lat, elat); end
      end
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1; m_sched = 0; m_key = '0;
      b128.in_valid = 1'b0; b128.in_keep_key = 1'b0; b128.plaintext = '0; b128.key = '0; b128.out_ready = 1'b1;
      b192.in_valid = 1'b0; b192.in_keep_key = 1'b0; b192.plaintext = '0; b192.key = '0; b192.out_ready = 1'b1;
      b256.in_valid = 1'b0; b256.in_keep_key = 1'b0; b256.plaintext = '0; b256.key = '0; b256.out_ready = 1'b1;
      build_sbox();
      test_reset();
      test_vec128();
      test_keep_key();
      test_vec_wide();
      test_hold_stall();
      test_enable_stall();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
